// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core: debounces RUN/STEP,
// drives the global core enable and interprets retired exit/LED syscalls.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] EXIT_CODE       = 32'd10,
    parameter logic [31:0] LED_CODE        = 32'd34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_code,
    input  logic [31:0] syscall_arg,
    output logic        cpu_en,
    output logic [2:0]  run_state,
    output logic        halted,
    output logic [31:0] led_data,
    output logic        led_valid,
    output logic [31:0] cycles_run
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    w_raw;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_q;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_pulse;
    logic          w_run_pulse;
    logic          w_step_pulse;
    logic          w_sys_exit;
    logic          w_sys_led;
    logic [31:0]   r_led_data;
    logic          r_led_valid;
    logic [31:0]   r_cycles_run;

    // Index 0 is RUN, index 1 is STEP.
    assign w_raw        = {btn_step, btn_run};
    assign w_pulse      = r_lvl & ~r_lvl_q;
    assign w_run_pulse  = w_pulse[0];
    assign w_step_pulse = w_pulse[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl   <= '0;
            r_lvl_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_lvl_q <= r_lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_raw[i] != r_lvl[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_lvl[i] <= w_raw[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign cpu_en     = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_sys_exit = syscall_valid && cpu_en && (syscall_code == EXIT_CODE);
    assign w_sys_led  = syscall_valid && cpu_en && (syscall_code == LED_CODE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_PAUSE: begin
                if (w_run_pulse)       w_next = S_RUN;
                else if (w_step_pulse) w_next = S_STEP;
            end
            S_RUN: begin
                if (w_sys_exit)       w_next = S_HALT;
                else if (w_run_pulse) w_next = S_PAUSE;
            end
            S_STEP:  w_next = w_sys_exit ? S_HALT : S_PAUSE;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_led_data   <= '0;
            r_led_valid  <= 1'b0;
            r_cycles_run <= '0;
        end else begin
            r_state     <= w_next;
            r_led_valid <= w_sys_led;
            if (w_sys_led) begin
                r_led_data <= syscall_arg;
            end
            if (cpu_en) begin
                r_cycles_run <= r_cycles_run + 32'd1;
            end
        end
    end

    assign run_state  = r_state;
    assign halted     = (r_state == S_HALT);
    assign led_data   = r_led_data;
    assign led_valid  = r_led_valid;
    assign cycles_run = r_cycles_run;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_run;
    logic        btn_step;
    logic        syscall_valid;
    logic [31:0] syscall_code;
    logic [31:0] syscall_arg;
    logic        cpu_en;
    logic [2:0]  run_state;
    logic        halted;
    logic [31:0] led_data;
    logic        led_valid;
    logic [31:0] cycles_run;

    int checks   = 0;
    int failures = 0;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .EXIT_CODE(32'd10),
        .LED_CODE(32'd34)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_run(btn_run),
        .btn_step(btn_step),
        .syscall_valid(syscall_valid),
        .syscall_code(syscall_code),
        .syscall_arg(syscall_arg),
        .cpu_en(cpu_en),
        .run_state(run_state),
        .halted(halted),
        .led_data(led_data),
        .led_valid(led_valid),
        .cycles_run(cycles_run)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic r, input logic s, input int n);
        btn_run  = r;
        btn_step = s;
        tick(n);
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_run = 1'b1; btn_step = 1'b0;
        syscall_valid = 1'b0; syscall_code = '0; syscall_arg = '0;
        tick(2);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", run_state); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
        checks++; if (led_data !== 32'h0) begin failures++; $display("FAIL reset_led_data got=%h exp=0", led_data); end
        checks++; if (led_valid !== 1'b0) begin failures++; $display("FAIL reset_led_valid got=%0b exp=0", led_valid); end
        checks++; if (cycles_run !== 32'h0) begin failures++; $display("FAIL reset_cycles got=%h exp=0", cycles_run); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        rst = 1'b0;
        tick(4);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL latency_edge4 got=%0d exp=0", run_state); end
        tick(1);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL latency_edge5_state got=%0d exp=1", run_state); end
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL latency_edge5_en got=%0b exp=1", cpu_en); end
        checks++; if (cycles_run !== 32'd0) begin failures++; $display("FAIL latency_edge5_cycles got=%0d exp=0", cycles_run); end
        tick(3);
        checks++; if (cycles_run !== 32'd3) begin failures++; $display("FAIL cycles_edge8 got=%0d exp=3", cycles_run); end
        hold(1'b0, 1'b0, 4);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL release_no_pulse got=%0d exp=1", run_state); end
        checks++; if (cycles_run !== 32'd7) begin failures++; $display("FAIL release_cycles got=%0d exp=7", cycles_run); end
    endtask

    task automatic test_step;
        hold(1'b1, 1'b0, 4);
        tick(1);
        checks++; if (run_state !== 3'd2) begin failures++; $display("FAIL pause_state got=%0d exp=2", run_state); end
        checks++; if (cycles_run !== 32'd12) begin failures++; $display("FAIL pause_cycles got=%0d exp=12", cycles_run); end
        hold(1'b0, 1'b0, 4);
        for (int k = 0; k < 2; k++) begin
            hold(1'b0, 1'b1, 4);
            checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step%0d_pre_en got=%0b exp=0", k, cpu_en); end
            tick(1);
            checks++; if (run_state !== 3'd3) begin failures++; $display("FAIL step%0d_state got=%0d exp=3", k, run_state); end
            checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL step%0d_en got=%0b exp=1", k, cpu_en); end
            tick(1);
            checks++; if (run_state !== 3'd2) begin failures++; $display("FAIL step%0d_back got=%0d exp=2", k, run_state); end
            checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step%0d_post_en got=%0b exp=0", k, cpu_en); end
            checks++; if (cycles_run !== 32'(13 + k)) begin failures++; $display("FAIL step%0d_cycles got=%0d exp=%0d", k, cycles_run, 13 + k); end
            hold(1'b0, 1'b0, 4);
        end
    endtask

    task automatic test_both_buttons;
        hold(1'b1, 1'b1, 4);
        tick(1);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL both_run_wins got=%0d exp=1", run_state); end
        hold(1'b0, 1'b0, 4);
        checks++; if (cycles_run !== 32'd18) begin failures++; $display("FAIL both_cycles got=%0d exp=18", cycles_run); end
    endtask

    task automatic test_led;
        syscall_valid = 1'b1; syscall_code = 32'd34; syscall_arg = 32'h0000ABCD;
        tick(1);
        syscall_valid = 1'b0;
        checks++; if (led_data !== 32'h0000ABCD) begin failures++; $display("FAIL led_data got=%h exp=0000abcd", led_data); end
        checks++; if (led_valid !== 1'b1) begin failures++; $display("FAIL led_valid_pulse got=%0b exp=1", led_valid); end
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL led_state got=%0d exp=1", run_state); end
        tick(1);
        checks++; if (led_valid !== 1'b0) begin failures++; $display("FAIL led_valid_drop got=%0b exp=0", led_valid); end
        syscall_valid = 1'b1; syscall_code = 32'd5; syscall_arg = 32'h00001234;
        tick(1);
        syscall_valid = 1'b0;
        checks++; if (led_data !== 32'h0000ABCD) begin failures++; $display("FAIL other_code_led got=%h exp=0000abcd", led_data); end
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL other_code_state got=%0d exp=1", run_state); end
        hold(1'b1, 1'b0, 4);
        tick(1);
        hold(1'b0, 1'b0, 4);
        syscall_valid = 1'b1; syscall_code = 32'd34; syscall_arg = 32'h00005555;
        tick(1);
        checks++; if (led_data !== 32'h0000ABCD) begin failures++; $display("FAIL paused_led_data got=%h exp=0000abcd", led_data); end
        checks++; if (led_valid !== 1'b0) begin failures++; $display("FAIL paused_led_valid got=%0b exp=0", led_valid); end
        syscall_code = 32'd10;
        tick(1);
        syscall_valid = 1'b0;
        checks++; if (run_state !== 3'd2) begin failures++; $display("FAIL paused_exit_ignored got=%0d exp=2", run_state); end
        hold(1'b1, 1'b0, 4);
        tick(1);
        hold(1'b0, 1'b0, 4);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL resume_state got=%0d exp=1", run_state); end
        checks++; if (cycles_run !== 32'd30) begin failures++; $display("FAIL resume_cycles got=%0d exp=30", cycles_run); end
    endtask

    task automatic test_exit;
        syscall_valid = 1'b1; syscall_code = 32'd10; syscall_arg = '0;
        tick(1);
        syscall_valid = 1'b0;
        checks++; if (run_state !== 3'd4) begin failures++; $display("FAIL exit_state got=%0d exp=4", run_state); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL exit_halted got=%0b exp=1", halted); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL exit_en got=%0b exp=0", cpu_en); end
        checks++; if (cycles_run !== 32'd31) begin failures++; $display("FAIL exit_cycles got=%0d exp=31", cycles_run); end
        hold(1'b1, 1'b0, 4);
        tick(1);
        checks++; if (run_state !== 3'd4) begin failures++; $display("FAIL halt_run_ignored got=%0d exp=4", run_state); end
        hold(1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 4);
        tick(1);
        checks++; if (run_state !== 3'd4) begin failures++; $display("FAIL halt_step_ignored got=%0d exp=4", run_state); end
        checks++; if (cycles_run !== 32'd31) begin failures++; $display("FAIL halt_cycles got=%0d exp=31", cycles_run); end
        hold(1'b0, 1'b0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL halt_rst_state got=%0d exp=0", run_state); end
        checks++; if (led_data !== 32'h0) begin failures++; $display("FAIL halt_rst_led got=%h exp=0", led_data); end
        checks++; if (cycles_run !== 32'h0) begin failures++; $display("FAIL halt_rst_cycles got=%h exp=0", cycles_run); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_rst_halted got=%0b exp=0", halted); end
    endtask

    task automatic test_glitch;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 6);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL run_glitch_state got=%0d exp=0", run_state); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL run_glitch_en got=%0b exp=0", cpu_en); end
        hold(1'b0, 1'b1, 3);
        hold(1'b0, 1'b0, 6);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL step_glitch_state got=%0d exp=0", run_state); end
    endtask

    task automatic test_wrap;
        force dut.r_cycles_run = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycles_run;
        hold(1'b1, 1'b0, 4);
        tick(1);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL wrap_run_state got=%0d exp=1", run_state); end
        checks++; if (cycles_run !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_preload got=%h exp=fffffffe", cycles_run); end
        tick(1);
        checks++; if (cycles_run !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffffffff", cycles_run); end
        tick(1);
        checks++; if (cycles_run !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", cycles_run); end
        hold(1'b0, 1'b0, 4);
    endtask

    task automatic test_reset_mid_debounce;
        hold(1'b1, 1'b0, 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL mid_rst_edge3 got=%0d exp=0", run_state); end
        tick(1);
        checks++; if (run_state !== 3'd0) begin failures++; $display("FAIL mid_rst_edge4 got=%0d exp=0", run_state); end
        tick(1);
        checks++; if (run_state !== 3'd1) begin failures++; $display("FAIL mid_rst_edge5 got=%0d exp=1", run_state); end
        hold(1'b0, 1'b0, 4);
    endtask

    initial begin
        test_reset();
        test_step();
        test_both_buttons();
        test_led();
        test_exit();
        test_glitch();
        test_wrap();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
